// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: holds the fetch-group base and drives three sequential slot PCs to the BPU and icache.
// Latency: pc/valid_fetch/stall_bpu are combinational from base, state and inputs; base updates one cycle after acceptance or redirect.
// Backpressure: stall_fetch holds the base (RUN -> STALL); redirects override stall in any state except BOOT.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_fetch,
    input  logic        flush_rob,
    input  logic [31:0] target_rob,
    input  logic        flush_decoder,
    input  logic [31:0] target_decoder,
    input  logic [31:0] target_predict [2:0],
    input  logic [2:0]  valid_predict,
    input  logic [2:0]  Predict,
    output logic [31:0] pc [2:0],
    output logic [2:0]  valid_fetch,
    output logic        stall_bpu,
    output logic [31:0] cnt_group,
    output logic [31:0] cnt_taken
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] base;
    logic [2:0]  taken;
    logic        redirect;
    logic [31:0] redir_tgt;
    logic [31:0] seq_next;
    logic        advance;

    // Slot PCs are fixed 4-byte offsets from the base, wrapping at 2^32.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pc[i] = base + 32'(4 * i);
        end
    end

    // A predicted-taken slot only counts if its target is word aligned.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            taken[i] = valid_predict[i] && Predict[i] && (target_predict[i][1:0] == 2'b00);
        end
    end

    // Redirect selection: ROB flush beats decoder flush; both are ignored while booting.
    always_comb begin
        redirect  = (flush_rob || flush_decoder) && (state != BOOT);
        redir_tgt = flush_rob ? target_rob : target_decoder;
    end

    // Next sequential base: lowest taken slot's target, else the group after this one.
    always_comb begin
        if (taken[0]) begin
            seq_next = target_predict[0];
        end else if (taken[1]) begin
            seq_next = target_predict[1];
        end else if (taken[2]) begin
            seq_next = target_predict[2];
        end else begin
            seq_next = base + 32'd12;
        end
    end

    // Slot masks and BPU freeze; slots after the first taken one are squashed.
    always_comb begin
        valid_fetch = 3'b000;
        if (state == RUN && !redirect) begin
            valid_fetch[0] = 1'b1;
            valid_fetch[1] = !taken[0];
            valid_fetch[2] = !(taken[0] || taken[1]);
        end
        stall_bpu = (state != RUN) || stall_fetch;
        advance   = (state == RUN) && !stall_fetch && !redirect;
    end

    // Base register, FSM and performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= RESET_PC;
            state     <= BOOT;
            cnt_group <= 32'd0;
            cnt_taken <= 32'd0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        base  <= redir_tgt & ~32'h3;
                        state <= RUN;
                    end else if (stall_fetch) begin
                        state <= STALL;
                    end else begin
                        base  <= seq_next;
                        state <= RUN;
                    end
                end
                STALL: begin
                    if (redirect) begin
                        base  <= redir_tgt & ~32'h3;
                        state <= RUN;
                    end else if (!stall_fetch) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
            if (advance) begin
                cnt_group <= cnt_group + 32'd1;
                if (|taken) begin
                    cnt_taken <= cnt_taken + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, meaning the first fetch-group base PC after reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port stall_fetch, input, 1 bit: downstream (icache/decode) cannot accept the current group.
REQ-005 SHALL have ports flush_rob, input, 1 bit, and target_rob, input, 32 bits: backend mispredict redirect and its target.
REQ-006 SHALL have ports flush_decoder, input, 1 bit, and target_decoder, input, 32 bits: decode-stage redirect and its target.
REQ-007 SHALL have port target_predict [2:0], input, 32 bits each: BPU predicted targets for the current pc slots.
REQ-008 SHALL have ports valid_predict [2:0] and Predict [2:0], input, 1 bit each: BPU hit and taken per slot.
REQ-009 SHALL have port pc [2:0], output, 32 bits each: the current fetch group, driven to the BPU and the icache.
REQ-010 SHALL have port valid_fetch [2:0], output, 1 bit each: per-slot instruction-valid mask.
REQ-011 SHALL have port stall_bpu, output, 1 bit: freezes BPU state.
REQ-012 SHALL have ports cnt_group and cnt_taken, output, 32 bits each: performance counters.

Function
REQ-013 SHALL hold a 32-bit base register and drive pc[i] = base + 4*i, combinationally, modulo 2^32.
REQ-014 SHALL define slot i as taken when valid_predict[i] && Predict[i] && target_predict[i][1:0] == 0; a misaligned predicted target is treated as not-taken.
REQ-015 SHALL set valid_fetch[i] = 1 in state RUN only when no slot j < i is taken; it is 0 in every other state.
REQ-016 SHALL compute seq_next as target_predict[k] of the lowest taken slot k, or base + 12 when no slot is taken.
REQ-017 SHALL implement FSM states BOOT, RUN and STALL.
REQ-018 BOOT: entered on rst; outputs valid_fetch = 0; advances to RUN after exactly one cycle; base stays at RESET_PC.
REQ-019 RUN: when stall_fetch = 0, base <= seq_next; when stall_fetch = 1, base is held and the FSM goes to STALL.
REQ-020 STALL: base is held and valid_fetch is 0; the FSM returns to RUN in the cycle after stall_fetch = 0.
REQ-021 SHALL drive stall_bpu = 1 in states BOOT and STALL, and in RUN while stall_fetch = 1.
REQ-022 SHALL apply redirect priority flush_rob > flush_decoder > seq_next; a redirect overrides stall in any state except BOOT.
REQ-023 On a redirect: base <= {target[31:2], 2'b00}; FSM goes to RUN; the next cycle presents the redirected group.
REQ-024 In the redirect cycle itself, valid_fetch SHALL be forced to 000.
REQ-025 A redirect arriving during BOOT SHALL be ignored.
REQ-026 cnt_group SHALL increment when RUN && !stall_fetch && no redirect.
REQ-027 cnt_taken SHALL increment under the same condition as cnt_group when any slot is taken.
REQ-028 Both counters SHALL wrap from 2^32-1 to 0.
REQ-029 A taken slot 2 SHALL only redirect the next base; all three slots remain valid.

Reset
REQ-030 When rst = 1 at a clock edge: base <= RESET_PC, FSM <= BOOT, cnt_group <= 0, cnt_taken <= 0.
REQ-031 In the cycle after rst: valid_fetch = 000, stall_bpu = 1, pc = {RESET_PC, RESET_PC+4, RESET_PC+8}.
REQ-032 Reset asserted mid-operation SHALL discard any pending stall or redirect; rst takes priority over every other input.

Verification
REQ-033 Release rst, no predictions, no stall -> one BOOT cycle, then pc[0] = 1c000000, 1c00000c, 1c000018 on successive cycles with valid_fetch = 111.
REQ-034 base = 1c000100, slot 1 taken with target 1c000400 -> valid_fetch = 011; next pc[0] = 1c000400; cnt_taken +1.
REQ-035 Slot 0 taken with target 1c000402 (misaligned) -> treated as not-taken; valid_fetch = 111; next base = base + 12.
REQ-036 stall_fetch held 3 cycles in RUN -> base unchanged, valid_fetch = 000 during STALL, stall_bpu = 1; resume at the same pc.
REQ-037 flush_rob (target 1c000800) and flush_decoder (target 1c000900) in the same cycle, with stall_fetch = 1 -> valid_fetch = 000 that cycle; next cycle pc[0] = 1c000800 in RUN.
REQ-038 Preload cnt_group = FFFFFFFF, advance one group -> cnt_group = 0; rst asserted during STALL -> BOOT with base = RESET_PC.
